// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch parameters and fetch FSM state type
package cpu_pkg;

  localparam int ADDR_W   = 8;
  localparam int INST_W   = 32;
  localparam int RESET_PC = 0;
  localparam int PC_INC   = 1;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    FULL = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {pc, inst} holding register behind the IF output register
module fetch_skid_buf import cpu_pkg::*; #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int INST_W = cpu_pkg::INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_unload,
  input  logic              i_clear,
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_pc,
  output logic [INST_W-1:0] o_inst
);

  logic              r_valid;
  logic [ADDR_W-1:0] r_pc;
  logic [INST_W-1:0] r_inst;

  // Emptying (clear/unload) wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_inst  <= '0;
    end else if (i_clear || i_unload) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - IF stage: PC, imem req/ack fetch, IF/ID output with stall and redirect
module instruction_fetch_unit import cpu_pkg::*; #(
  parameter int ADDR_W   = cpu_pkg::ADDR_W,
  parameter int INST_W   = cpu_pkg::INST_W,
  parameter int RESET_PC = cpu_pkg::RESET_PC,
  parameter int PC_INC   = cpu_pkg::PC_INC
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              id_stall,
  output logic              if_valid,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_drop_addr;
  logic              r_if_valid;
  logic [ADDR_W-1:0] r_if_pc;
  logic [INST_W-1:0] r_if_inst;

  logic              w_req;
  logic              w_ack;
  logic              w_slot_free;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_skid_load;
  logic              w_skid_unload;
  logic              w_skid_valid;
  logic [ADDR_W-1:0] w_skid_pc;
  logic [INST_W-1:0] w_skid_inst;

  assign w_req       = !rst && (r_state != FULL);
  assign w_ack       = imem_ack && w_req;
  assign w_slot_free = !r_if_valid || !id_stall;
  assign w_pc_next   = r_pc + ADDR_W'(PC_INC);

  assign w_skid_load   = !br_taken && (r_state == REQ) && w_ack && !w_slot_free;
  assign w_skid_unload = !br_taken && (r_state == FULL) && !id_stall;

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (br_taken),
    .i_pc     (r_pc),
    .i_inst   (imem_rdata),
    .o_valid  (w_skid_valid),
    .o_pc     (w_skid_pc),
    .o_inst   (w_skid_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= REQ;
      r_pc        <= ADDR_W'(RESET_PC);
      r_drop_addr <= '0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_inst   <= '0;
    end else if (br_taken) begin
      r_pc       <= br_target;
      r_if_valid <= 1'b0;
      // An unanswered request must still be retired before fetching the new target.
      case (r_state)
        REQ: begin
          if (w_ack) begin
            r_state <= REQ;
          end else begin
            r_drop_addr <= r_pc;
            r_state     <= DROP;
          end
        end
        FULL:    r_state <= REQ;
        DROP:    r_state <= w_ack ? REQ : DROP;
        default: r_state <= REQ;
      endcase
    end else begin
      case (r_state)
        REQ: begin
          if (w_ack) begin
            r_pc <= w_pc_next;
            if (w_slot_free) begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_pc;
              r_if_inst  <= imem_rdata;
            end else begin
              r_state <= FULL;
            end
          end else if (r_if_valid && !id_stall) begin
            r_if_valid <= 1'b0;
          end
        end
        FULL: begin
          if (!id_stall && w_skid_valid) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= w_skid_pc;
            r_if_inst  <= w_skid_inst;
            r_state    <= REQ;
          end
        end
        DROP: begin
          if (w_ack) begin
            r_state <= REQ;
          end
        end
        default: r_state <= REQ;
      endcase
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = (r_state == DROP) ? r_drop_addr : r_pc;
  assign if_valid  = r_if_valid;
  assign if_pc     = r_if_pc;
  assign if_inst   = r_if_inst;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - queue-model bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [IW-1:0] imem_rdata = '0;
  logic          br_taken = 1'b0;
  logic [AW-1:0] br_target = '0;
  logic          id_stall = 1'b0;
  logic          if_valid;
  logic [AW-1:0] if_pc;
  logic [IW-1:0] if_inst;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .id_stall   (id_stall),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst)
  );

  typedef struct {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } entry_t;

  // Model: words held for ID (output + skid) as a queue, plus pending abandoned request.
  entry_t        m_q[$];
  logic [AW-1:0] m_pc = '0;
  logic [AW-1:0] m_drop_addr = '0;
  bit            m_drop = 1'b0;
  int            req_cnt = 0;
  int            n_checks = 0;
  int            n_pass = 0;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {8'hC0, a, ~a, a ^ 8'h5A};
  endfunction

  function automatic bit m_req();
    return !rst && (m_drop || m_q.size() < 2);
  endfunction

  function automatic logic [AW-1:0] m_addr();
    return m_drop ? m_drop_addr : m_pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req()});
    if (m_req()) chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_addr()});
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_q.size() != 0});
    if (m_q.size() != 0) begin
      chk("if_pc", {24'd0, if_pc}, {24'd0, m_q[0].pc});
      chk("if_inst", if_inst, m_q[0].inst);
    end
  endtask

  task automatic model_step(input bit r, input bit br, input logic [AW-1:0] tgt,
                            input bit st, input bit ack, input logic [IW-1:0] data, input bit req);
    entry_t e;
    if (r) begin
      m_pc   = '0;
      m_drop = 1'b0;
      m_q.delete();
    end else if (br) begin
      if (req && !ack) begin
        if (!m_drop) m_drop_addr = m_pc;
        m_drop = 1'b1;
      end else begin
        m_drop = 1'b0;
      end
      m_q.delete();
      m_pc = tgt;
    end else begin
      if (m_q.size() != 0 && !st) void'(m_q.pop_front());
      if (ack) begin
        if (m_drop) begin
          m_drop = 1'b0;
        end else begin
          e.pc   = m_pc;
          e.inst = data;
          m_q.push_back(e);
          m_pc = m_pc + 8'd1;
        end
      end
    end
  endtask

  // lat: 0 = never ack, N = ack on the Nth cycle a request has been held.
  task automatic cyc(input bit r, input bit br, input logic [AW-1:0] tgt, input bit st, input int lat);
    bit            req;
    bit            ack;
    logic [AW-1:0] addr;
    @(negedge clk);
    rst       = r;
    br_taken  = br;
    br_target = tgt;
    id_stall  = st;
    req  = m_req();
    addr = m_addr();
    ack  = req && (lat != 0) && (req_cnt >= lat - 1);
    imem_ack   = ack;
    imem_rdata = ack ? mem_word(addr) : 32'hDEAD_BEEF;
    #1 compare();
    @(posedge clk);
    model_step(r, br, tgt, st, ack, imem_rdata, req);
    req_cnt = (req && !ack) ? req_cnt + 1 : 0;
    #1;
  endtask

  initial begin
    cyc(1, 0, 8'h00, 0, 1);
    cyc(1, 0, 8'h00, 0, 1);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", {24'd0, if_pc}, 32'd0);
    chk("rst_if_inst", if_inst, 32'd0);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);

    // Streaming, ack every cycle
    cyc(0, 0, 8'h00, 0, 1);
    chk("t1_pc0", {24'd0, if_pc}, 32'h00);
    chk("t1_inst0", if_inst, 32'hC000FF5A);
    for (int i = 0; i < 3; i++) cyc(0, 0, 8'h00, 0, 1);
    chk("t1_pc3", {24'd0, if_pc}, 32'h03);
    chk("t1_inst3", if_inst, 32'hC003FC59);

    // Slow imem: ack on third request cycle
    cyc(0, 0, 8'h00, 0, 3);
    chk("t2_gap", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 8'h00, 0, 3);
    cyc(0, 0, 8'h00, 0, 3);
    chk("t2_valid", {31'd0, if_valid}, 32'd1);
    chk("t2_pc4", {24'd0, if_pc}, 32'h04);
    cyc(0, 0, 8'h00, 0, 3);
    chk("t2_one_cycle", {31'd0, if_valid}, 32'd0);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t2_pc5", {24'd0, if_pc}, 32'h05);

    // Back-pressure fills the skid
    for (int i = 0; i < 4; i++) cyc(0, 0, 8'h00, 1, 1);
    chk("t3_hold_pc", {24'd0, if_pc}, 32'h05);
    chk("t3_hold_valid", {31'd0, if_valid}, 32'd1);
    chk("t3_req_off", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t3_pc6", {24'd0, if_pc}, 32'h06);
    chk("t3_addr7", {24'd0, imem_addr}, 32'h07);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t3_pc7", {24'd0, if_pc}, 32'h07);

    // Redirect with request outstanding
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 1, 8'h40, 0, 0);
    chk("t4_flush", {31'd0, if_valid}, 32'd0);
    chk("t4_drop_addr", {24'd0, imem_addr}, 32'h08);
    chk("t4_drop_req", {31'd0, imem_req}, 32'd1);
    cyc(0, 0, 8'h00, 0, 0);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t4_discard", {31'd0, if_valid}, 32'd0);
    chk("t4_addr40", {24'd0, imem_addr}, 32'h40);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t4_pc40", {24'd0, if_pc}, 32'h40);
    chk("t4_inst40", if_inst, 32'hC040BF1A);

    // Redirect during stall with full skid
    cyc(0, 0, 8'h00, 1, 1);
    chk("t5_full", {31'd0, imem_req}, 32'd0);
    cyc(0, 1, 8'h20, 1, 1);
    chk("t5_flush", {31'd0, if_valid}, 32'd0);
    chk("t5_addr20", {24'd0, imem_addr}, 32'h20);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t5_pc20", {24'd0, if_pc}, 32'h20);

    // PC wrap, then reset while dropping
    cyc(0, 1, 8'hFE, 0, 1);
    chk("t6_discard", {31'd0, if_valid}, 32'd0);
    chk("t6_addrFE", {24'd0, imem_addr}, 32'hFE);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t6_pcFE", {24'd0, if_pc}, 32'hFE);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t6_pc00", {24'd0, if_pc}, 32'h00);
    chk("t6_inst00", if_inst, 32'hC000FF5A);
    cyc(0, 1, 8'h90, 0, 0);
    chk("t6_drop_addr", {24'd0, imem_addr}, 32'h01);
    cyc(1, 0, 8'h00, 0, 0);
    chk("t6_rst_valid", {31'd0, if_valid}, 32'd0);
    chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
    cyc(0, 0, 8'h00, 0, 0);
    chk("t6_req_again", {31'd0, imem_req}, 32'd1);
    chk("t6_addr_reset", {24'd0, imem_addr}, 32'h00);
    cyc(0, 0, 8'h00, 0, 1);
    chk("t6_pc_reset", {24'd0, if_pc}, 32'h00);
    cyc(0, 0, 8'h00, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
